// File: rtl/spram_arbiter_pkg.sv
// Shared types and constants for the three-port SPRAM arbiter.
package spram_arbiter_pkg;

    localparam int AW = 14;  // SP256K word address width
    localparam int DW = 16;  // data width
    localparam int MW = 4;   // nibble write-mask width

    localparam int PORT_DISP = 0;
    localparam int PORT_CPU  = 1;
    localparam int PORT_SPR  = 2;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_STANDBY = 2'd1,
        ST_WAKE    = 2'd2
    } state_t;

endpackage

// File: rtl/spram_arbiter_sp256k.sv
// Behavioural wrapper for the SP256K 16K x 16 single-port RAM macro.
module spram_arbiter_sp256k
    import spram_arbiter_pkg::*;
(
    input  logic          ck,
    input  logic [AW-1:0] ad,
    input  logic [DW-1:0] di,
    input  logic [MW-1:0] maskwe,
    input  logic          we,
    input  logic          cs,
    input  logic          stdby,
    input  logic          sleep,
    input  logic          pwroff_n,
    output logic [DW-1:0] dout
);

    localparam int NW = DW / MW;

    logic [DW-1:0] mem [2**AW];
    logic          live;

    assign live = cs && !stdby && !sleep && pwroff_n;

    // Each maskwe bit enables one nibble of the word; DO holds between reads.
    always_ff @(posedge ck) begin
        if (live && we) begin
            for (int i = 0; i < MW; i++) begin
                if (maskwe[i]) mem[ad][i*NW +: NW] <= di[i*NW +: NW];
            end
        end
        if (live && !we) dout <= mem[ad];
    end

endmodule

// File: rtl/spram_arbiter.sv
// Three-port SPRAM arbiter: fixed-priority display port, round-robin CPU/sprite,
// with idle-triggered standby and a timed wake-up sequence.
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    input  logic [MW-1:0] wmask0,
    input  logic [MW-1:0] wmask1,
    input  logic [MW-1:0] wmask2,
    output logic [2:0]    ack,
    output logic [2:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic          stdby
);

    localparam logic [7:0] IDLE_MAX  = 8'(IDLE_CYCLES);
    localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES);

    state_t        state;
    logic [7:0]    idle_cnt;
    logic [7:0]    wake_cnt;
    logic          rr_last;   // 1: port 2 granted last, so port 1 wins next tie

    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_di;
    logic [MW-1:0] ram_mask;

    // Zero-latency grant; nothing is granted outside ACTIVE or during reset.
    always_comb begin
        ack = '0;
        if (state == ST_ACTIVE && !rst) begin
            if (req[PORT_DISP]) begin
                ack[PORT_DISP] = 1'b1;
            end else if (req[PORT_CPU] && req[PORT_SPR]) begin
                if (rr_last) ack[PORT_CPU] = 1'b1;
                else         ack[PORT_SPR] = 1'b1;
            end else if (req[PORT_CPU]) begin
                ack[PORT_CPU] = 1'b1;
            end else if (req[PORT_SPR]) begin
                ack[PORT_SPR] = 1'b1;
            end
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_ad   = '0;
        ram_di   = '0;
        ram_mask = '0;
        if (ack[PORT_DISP]) begin
            ram_we   = we[PORT_DISP];
            ram_ad   = addr0;
            ram_di   = wdata0;
            ram_mask = wmask0;
        end else if (ack[PORT_CPU]) begin
            ram_we   = we[PORT_CPU];
            ram_ad   = addr1;
            ram_di   = wdata1;
            ram_mask = wmask1;
        end else if (ack[PORT_SPR]) begin
            ram_we   = we[PORT_SPR];
            ram_ad   = addr2;
            ram_di   = wdata2;
            ram_mask = wmask2;
        end
    end

    assign ram_cs = |ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ACTIVE;
            idle_cnt <= '0;
            wake_cnt <= '0;
            rr_last  <= 1'b1;
            stdby    <= 1'b0;
            rvalid   <= '0;
        end else begin
            rvalid <= (ram_cs && !ram_we) ? ack : 3'b000;

            if (ack[PORT_CPU])      rr_last <= 1'b0;
            else if (ack[PORT_SPR]) rr_last <= 1'b1;

            case (state)
                ST_ACTIVE: begin
                    if (|req) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != IDLE_MAX) begin
                        idle_cnt <= idle_cnt + 8'd1;
                        // Enter standby on the edge where the count reaches the limit.
                        if (IDLE_CYCLES != 0 && idle_cnt + 8'd1 == IDLE_MAX) begin
                            state <= ST_STANDBY;
                            stdby <= 1'b1;
                        end
                    end
                end
                ST_STANDBY: begin
                    if (|req) begin
                        state    <= ST_WAKE;
                        stdby    <= 1'b0;
                        wake_cnt <= WAKE_LOAD;
                        idle_cnt <= '0;
                    end
                end
                ST_WAKE: begin
                    // Runs to completion regardless of req activity.
                    if (wake_cnt <= 8'd1) state <= ST_ACTIVE;
                    else                  wake_cnt <= wake_cnt - 8'd1;
                end
                default: begin
                    state <= ST_ACTIVE;
                    stdby <= 1'b0;
                end
            endcase
        end
    end

    spram_arbiter_sp256k u_spram (
        .ck       (clk),
        .ad       (ram_ad),
        .di       (ram_di),
        .maskwe   (ram_mask),
        .we       (ram_we),
        .cs       (ram_cs),
        .stdby    (stdby),
        .sleep    (1'b0),
        .pwroff_n (1'b1),
        .dout     (rdata)
    );

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter: grants, masked writes, round-robin, standby, reset, streaming.
module tb_spram_arbiter;
    import spram_arbiter_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    req, we;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [DW-1:0] wdata0, wdata1, wdata2;
    logic [MW-1:0] wmask0, wmask1, wmask2;
    logic [2:0]    ack, rvalid;
    logic [DW-1:0] rdata;
    logic          stdby;

    int vectors = 0;
    int miscompares = 0;

    spram_arbiter #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr0  (addr0),
        .addr1  (addr1),
        .addr2  (addr2),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .wdata2 (wdata2),
        .wmask0 (wmask0),
        .wmask1 (wmask1),
        .wmask2 (wmask2),
        .ack    (ack),
        .rvalid (rvalid),
        .rdata  (rdata),
        .stdby  (stdby)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked 1 time unit later.
    task automatic next();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [15:0] pat(input int k);
        return 16'(32'hA000 + k * 32'h0111);
    endfunction

    initial begin
        logic [2:0] e;
        req = '0; we = '0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
        wmask0 = '0; wmask1 = '0; wmask2 = '0;

        next(); settle();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_stdby", 32'(stdby), 32'h0);
        next(); req = 3'b001; settle();
        chk("rst_ack_gated", 32'(ack), 32'h0);

        // Preload 0x0123 = 0xBEEF through port 1, then read it back
        next(); rst = 1'b0; req = 3'b010; we = 3'b010;
        addr1 = 14'h0123; wdata1 = 16'hBEEF; wmask1 = 4'hF; settle();
        chk("wr_beef_ack", 32'(ack), 32'h2);
        next(); we = 3'b000; settle();
        chk("rd_beef_ack", 32'(ack), 32'h2);
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        next(); req = 3'b000; settle();
        chk("rd_beef_rvalid", 32'(rvalid), 32'h2);
        chk("rd_beef_rdata", 32'(rdata), 32'hBEEF);

        // Masked write on port 2
        next(); req = 3'b100; we = 3'b100; addr2 = 14'h0200; wdata2 = 16'h0000; wmask2 = 4'hF; settle();
        chk("clr_ack", 32'(ack), 32'h4);
        next(); wdata2 = 16'hFFFF; wmask2 = 4'b0011; settle();
        chk("mask_wr_ack", 32'(ack), 32'h4);
        next(); we = 3'b000; settle();
        chk("mask_rd_ack", 32'(ack), 32'h4);
        next(); req = 3'b000; settle();
        chk("mask_rvalid", 32'(rvalid), 32'h4);
        chk("mask_rdata", 32'(rdata), 32'h00FF);

        // Contention: all three, each dropping after its ack
        addr0 = 14'h0123; addr1 = 14'h0200; addr2 = 14'h0123; we = 3'b000;
        next(); req = 3'b111; settle();
        chk("cont_p0", 32'(ack), 32'h1);
        next(); req = 3'b110; settle();
        chk("cont_p1", 32'(ack), 32'h2);
        chk("cont_rv0", 32'(rvalid), 32'h1);
        chk("cont_rd0", 32'(rdata), 32'hBEEF);
        next(); req = 3'b100; settle();
        chk("cont_p2", 32'(ack), 32'h4);
        chk("cont_rv1", 32'(rvalid), 32'h2);
        chk("cont_rd1", 32'(rdata), 32'h00FF);
        next(); req = 3'b110; settle();
        chk("rr_first", 32'(ack), 32'h2);
        chk("cont_rv2", 32'(rvalid), 32'h4);
        chk("cont_rd2", 32'(rdata), 32'hBEEF);
        e = 3'b100;
        for (int k = 0; k < 4; k++) begin
            next(); settle();
            chk("rr_alt", 32'(ack), 32'(e));
            e = (e == 3'b100) ? 3'b010 : 3'b100;
        end

        // Standby after 4 idle cycles, then wake-up sequence
        next(); req = 3'b000; settle();
        chk("idle1_stdby", 32'(stdby), 32'h0);
        for (int k = 0; k < 3; k++) begin
            next(); settle();
            chk("idle_stdby", 32'(stdby), 32'h0);
        end
        next(); settle();
        chk("stdby_entry", 32'(stdby), 32'h1);
        next(); settle();
        chk("stdby_hold", 32'(stdby), 32'h1);
        next(); req = 3'b001; addr0 = 14'h0123; settle();
        chk("wake_w_ack", 32'(ack), 32'h0);
        chk("wake_w_stdby", 32'(stdby), 32'h1);
        next(); settle();
        chk("wake_w1_stdby", 32'(stdby), 32'h0);
        chk("wake_w1_ack", 32'(ack), 32'h0);
        next(); settle();
        chk("wake_w2_ack", 32'(ack), 32'h0);
        next(); settle();
        chk("wake_w3_ack", 32'(ack), 32'h1);
        next(); req = 3'b000; settle();
        chk("wake_rvalid", 32'(rvalid), 32'h1);
        chk("wake_rdata", 32'(rdata), 32'hBEEF);

        // Reset in the cycle after a read ack
        next(); req = 3'b010; addr1 = 14'h0200; settle();
        chk("pre_rst_ack", 32'(ack), 32'h2);
        next(); req = 3'b000; rst = 1'b1; settle();
        chk("rst_rvalid_clr", 32'(rvalid), 32'h0);
        next(); req = 3'b110; settle();
        chk("rst_no_ack", 32'(ack), 32'h0);
        chk("rst_rvalid_hold", 32'(rvalid), 32'h0);
        next(); rst = 1'b0; settle();
        chk("post_rst_rr", 32'(ack), 32'h2);
        chk("post_rst_stdby", 32'(stdby), 32'h0);
        next(); req = 3'b000; settle();
        chk("post_rst_rvalid", 32'(rvalid), 32'h2);
        chk("post_rst_rdata", 32'(rdata), 32'h00FF);

        // Back-to-back: port 0 writes 0..7, then streams reads 0..7
        for (int k = 0; k < 8; k++) begin
            next(); req = 3'b001; we = 3'b001; addr0 = 14'(k); wdata0 = pat(k); wmask0 = 4'hF; settle();
            chk("b2b_wr_ack", 32'(ack), 32'h1);
        end
        for (int k = 0; k < 8; k++) begin
            next(); we = 3'b000; addr0 = 14'(k); settle();
            chk("b2b_rd_ack", 32'(ack), 32'h1);
            if (k > 0) begin
                chk("b2b_rvalid", 32'(rvalid), 32'h1);
                chk("b2b_rdata", 32'(rdata), 32'(pat(k - 1)));
            end
        end
        next(); req = 3'b000; settle();
        chk("b2b_rvalid_last", 32'(rvalid), 32'h1);
        chk("b2b_rdata_last", 32'(rdata), 32'(pat(7)));
        next(); settle();
        chk("b2b_rvalid_end", 32'(rvalid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
